// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the gate-level ALU. Holds the opcode
//               encodings, the operand and result widths, and the value the
//               ALU produces for reserved opcodes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int OP_W  = 4;
   localparam int RES_W = 2 * OP_W;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;

   // Opcodes 5..7 produce this value.
   localparam logic [RES_W-1:0] RES_RESERVED = '0;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder built from gate primitives. Used for the
//               ripple adder/subtractor and the multiplier partial-product
//               rows.
// Ports       : a, b, cin - addend bits and carry in
//               s, cout   - sum bit and carry out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
   input  wire logic a,
   input  wire logic b,
   input  wire logic cin,
   output logic      s,
   output logic      cout
);

   logic w_axb;
   logic w_ab;
   logic w_cx;

   xor u_x0 (w_axb, a, b);
   xor u_x1 (s, w_axb, cin);
   and u_a0 (w_ab, a, b);
   and u_a1 (w_cx, cin, w_axb);
   or  u_o0 (cout, w_ab, w_cx);

endmodule
`default_nettype wire

// File: rtl/alu_gatelevel.sv
`default_nettype none
// ============================================================================
// Module      : alu_gatelevel
// Description : Gate-level unsigned ALU (ADD, SUB, MUL, AND, OR) with a
//               single registered output stage, one-cycle latency and no
//               handshake. Only the output register is behavioral.
// Ports       : i_clk  - clock, rising edge
//               i_rst  - synchronous active-high reset, clears o_dat
//               i_op1  - operand A (unsigned, OP_W bits)
//               i_op2  - operand B (unsigned, OP_W bits)
//               i_ctrl - operation select (0 ADD,1 SUB,2 MUL,3 AND,4 OR)
//               o_dat  - registered result (RES_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_gatelevel #(
   parameter int OP_W  = alu_pkg::OP_W,
   parameter int RES_W = alu_pkg::RES_W
) (
   input  wire logic             i_clk,
   input  wire logic             i_rst,
   input  wire logic [OP_W-1:0]  i_op1,
   input  wire logic [OP_W-1:0]  i_op2,
   input  wire logic [2:0]       i_ctrl,
   output logic      [RES_W-1:0] o_dat
);

   import alu_pkg::*;

   localparam int                 c_NUM_OPS  = 5;
   // Index o of this vector holds the opcode for select line w_sel[o].
   localparam logic [3*c_NUM_OPS-1:0] c_OP_CODES = {OP_OR, OP_AND, OP_MUL, OP_SUB, OP_ADD};
   localparam logic [RES_W-1:0]   c_RES_RSVD = RES_W'(RES_RESERVED);

   // ------------------------------------------------------------------------
   // Opcode decode: each select is high when every ctrl bit matches its code
   // ------------------------------------------------------------------------
   logic [c_NUM_OPS-1:0]      w_sel;
   logic [c_NUM_OPS-1:0]      w_any_diff;
   logic [c_NUM_OPS-1:0][2:0] w_diff;
   logic                      w_any_sel;
   logic                      w_sel_rsvd;
   logic                      w_sel_addsub;

   for (genvar o = 0; o < c_NUM_OPS; o++) begin : g_dec
      for (genvar b = 0; b < 3; b++) begin : g_bit
         xor u_x (w_diff[o][b], i_ctrl[b], c_OP_CODES[3*o+b]);
      end
      or  u_o (w_any_diff[o], w_diff[o][0], w_diff[o][1], w_diff[o][2]);
      not u_n (w_sel[o], w_any_diff[o]);
   end

   or  u_any  (w_any_sel, w_sel[0], w_sel[1], w_sel[2], w_sel[3], w_sel[4]);
   not u_rsvd (w_sel_rsvd, w_any_sel);
   or  u_as   (w_sel_addsub, w_sel[0], w_sel[1]);

   // ------------------------------------------------------------------------
   // Ripple adder/subtractor: SUB computes A + ~B + 1 by inverting B and
   // injecting the SUB select as carry in.
   // ------------------------------------------------------------------------
   logic [RES_W-1:0] w_a_ext;
   logic [RES_W-1:0] w_b_ext;
   logic [RES_W-1:0] w_b_inv;
   logic [RES_W-1:0] w_sum;
   logic [RES_W:0]   w_carry;
   logic             w_unused_cout;

   assign w_a_ext    = {{(RES_W-OP_W){1'b0}}, i_op1};
   assign w_b_ext    = {{(RES_W-OP_W){1'b0}}, i_op2};
   assign w_carry[0] = w_sel[1];

   for (genvar k = 0; k < RES_W; k++) begin : g_addsub
      xor u_binv (w_b_inv[k], w_b_ext[k], w_sel[1]);
      full_adder u_fa (
         .a    (w_a_ext[k]),
         .b    (w_b_inv[k]),
         .cin  (w_carry[k]),
         .s    (w_sum[k]),
         .cout (w_carry[k+1])
      );
   end

   // Results wrap modulo 2^RES_W, so the final carry is dropped.
   assign w_unused_cout = w_carry[RES_W];

   // ------------------------------------------------------------------------
   // Array multiplier. Row i adds partial product row i to the upper bits of
   // row i-1 (with its carry as the new MSB); bit 0 of each row is final.
   // ------------------------------------------------------------------------
   logic [OP_W-1:0][OP_W-1:0] w_pp;
   logic [OP_W-1:0][OP_W-1:0] w_row_s;
   logic [OP_W-1:0]           w_row_c;
   logic [RES_W-1:0]          w_prod;

   for (genvar i = 0; i < OP_W; i++) begin : g_pp
      for (genvar j = 0; j < OP_W; j++) begin : g_col
         and u_pp (w_pp[i][j], i_op1[j], i_op2[i]);
      end
   end

   assign w_row_s[0] = w_pp[0];
   assign w_row_c[0] = 1'b0;

   for (genvar i = 1; i < OP_W; i++) begin : g_row
      logic [OP_W-1:0] w_x;
      logic [OP_W:0]   w_rc;

      assign w_rc[0] = 1'b0;
      for (genvar j = 0; j < OP_W; j++) begin : g_col
         if (j < OP_W - 1) begin : g_mid
            assign w_x[j] = w_row_s[i-1][j+1];
         end else begin : g_top
            assign w_x[j] = w_row_c[i-1];
         end
         full_adder u_fa (
            .a    (w_x[j]),
            .b    (w_pp[i][j]),
            .cin  (w_rc[j]),
            .s    (w_row_s[i][j]),
            .cout (w_rc[j+1])
         );
      end
      assign w_row_c[i] = w_rc[OP_W];
   end

   for (genvar i = 0; i < OP_W; i++) begin : g_prod_lo
      assign w_prod[i] = w_row_s[i][0];
   end
   assign w_prod[RES_W-1:OP_W] = {w_row_c[OP_W-1], w_row_s[OP_W-1][OP_W-1:1]};

   // ------------------------------------------------------------------------
   // Bitwise logic, zero-extended to the result width
   // ------------------------------------------------------------------------
   logic [RES_W-1:0] w_andv;
   logic [RES_W-1:0] w_orv;

   for (genvar k = 0; k < OP_W; k++) begin : g_logic
      and u_and (w_andv[k], i_op1[k], i_op2[k]);
      or  u_or  (w_orv[k],  i_op1[k], i_op2[k]);
   end
   assign w_andv[RES_W-1:OP_W] = '0;
   assign w_orv[RES_W-1:OP_W]  = '0;

   // ------------------------------------------------------------------------
   // One-hot AND-OR result mux
   // ------------------------------------------------------------------------
   logic [RES_W-1:0]      w_res;
   logic [RES_W-1:0][4:0] w_term;

   for (genvar k = 0; k < RES_W; k++) begin : g_mux
      and u_t0 (w_term[k][0], w_sel_addsub, w_sum[k]);
      and u_t1 (w_term[k][1], w_sel[2],     w_prod[k]);
      and u_t2 (w_term[k][2], w_sel[3],     w_andv[k]);
      and u_t3 (w_term[k][3], w_sel[4],     w_orv[k]);
      and u_t4 (w_term[k][4], w_sel_rsvd,   c_RES_RSVD[k]);
      or  u_o  (w_res[k], w_term[k][0], w_term[k][1], w_term[k][2],
                w_term[k][3], w_term[k][4]);
   end

   // ------------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------------
   logic [RES_W-1:0] dat_d;
   logic [RES_W-1:0] dat_q;

   always_comb begin
      dat_d = w_res;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dat_q <= '0;
      end else begin
         dat_q <= dat_d;
      end
   end

   assign o_dat = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_gatelevel.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_gatelevel
// Description : Self-checking bench for alu_gatelevel. Directed vector table,
//               reset/hold sequences, and a full opcode x operand sweep
//               against a behavioral golden model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_gatelevel;

   import alu_pkg::*;

   logic       i_clk;
   logic       i_rst;
   logic [3:0] i_op1;
   logic [3:0] i_op2;
   logic [2:0] i_ctrl;
   logic [7:0] o_dat;

   int n_cmp;
   int n_err;

   alu_gatelevel #(.OP_W(4), .RES_W(8)) u_dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_op1  (i_op1),
      .i_op2  (i_op2),
      .i_ctrl (i_ctrl),
      .o_dat  (o_dat)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] c;
      logic [7:0] exp;
   } vec_t;

   localparam int c_NVEC = 16;
   vec_t vecs [c_NVEC];

   // Behavioral reference: case on the opcode, wrapping at 8 bits.
   function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] c);
      logic [7:0] ea;
      logic [7:0] eb;
      ea = {4'b0, a};
      eb = {4'b0, b};
      case (c)
         OP_ADD:  return ea + eb;
         OP_SUB:  return ea - eb;
         OP_MUL:  return ea * eb;
         OP_AND:  return ea & eb;
         OP_OR:   return ea | eb;
         default: return RES_RESERVED;
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] exp);
      n_cmp++;
      if (o_dat !== exp) begin
         n_err++;
         $display("FAIL %s: o_dat=%h expected %h (op1=%0d op2=%0d ctrl=%0d rst=%0b)",
                  name, o_dat, exp, i_op1, i_op2, i_ctrl, i_rst);
      end
   endtask

   // Drive inputs, clock once, then sample 1 time unit after the edge.
   task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] c);
      i_rst  = r;
      i_op1  = a;
      i_op2  = b;
      i_ctrl = c;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      vecs[0]  = '{a: 4'd15, b: 4'd15, c: 3'd0, exp: 8'd30};
      vecs[1]  = '{a: 4'd3,  b: 4'd5,  c: 3'd1, exp: 8'hFE};
      vecs[2]  = '{a: 4'd9,  b: 4'd4,  c: 3'd1, exp: 8'd5};
      vecs[3]  = '{a: 4'd15, b: 4'd15, c: 3'd2, exp: 8'd225};
      vecs[4]  = '{a: 4'd0,  b: 4'd7,  c: 3'd2, exp: 8'd0};
      vecs[5]  = '{a: 4'hC,  b: 4'hA,  c: 3'd3, exp: 8'h08};
      vecs[6]  = '{a: 4'hC,  b: 4'hA,  c: 3'd4, exp: 8'h0E};
      vecs[7]  = '{a: 4'hC,  b: 4'hA,  c: 3'd6, exp: 8'h00};
      vecs[8]  = '{a: 4'd0,  b: 4'd15, c: 3'd1, exp: 8'hF1};
      vecs[9]  = '{a: 4'd15, b: 4'd0,  c: 3'd1, exp: 8'd15};
      vecs[10] = '{a: 4'd7,  b: 4'd9,  c: 3'd2, exp: 8'd63};
      vecs[11] = '{a: 4'd15, b: 4'd15, c: 3'd5, exp: 8'h00};
      vecs[12] = '{a: 4'd15, b: 4'd15, c: 3'd7, exp: 8'h00};
      vecs[13] = '{a: 4'd0,  b: 4'd0,  c: 3'd0, exp: 8'd0};
      vecs[14] = '{a: 4'd8,  b: 4'd9,  c: 3'd0, exp: 8'd17};
      vecs[15] = '{a: 4'd15, b: 4'd15, c: 3'd1, exp: 8'd0};

      // Reset state
      step(1'b1, 4'd15, 4'd15, 3'd2);
      step(1'b1, 4'd15, 4'd15, 3'd2);
      check("reset_state", 8'h00);

      // Directed table, one vector per cycle
      for (int v = 0; v < c_NVEC; v++) begin
         step(1'b0, vecs[v].a, vecs[v].b, vecs[v].c);
         check($sformatf("vec%0d", v), vecs[v].exp);
      end

      // Reset on top of a 15*15 multiply, then release
      step(1'b0, 4'd15, 4'd15, 3'd2);
      check("mul_before_rst", 8'd225);
      step(1'b1, 4'd15, 4'd15, 3'd2);
      check("rst_clears", 8'h00);
      step(1'b0, 4'd15, 4'd15, 3'd2);
      check("first_after_rst", 8'd225);

      // Output holds between edges despite input changes
      i_op1  = 4'd1;
      i_op2  = 4'd1;
      i_ctrl = 3'd0;
      #3;
      check("hold_between_edges", 8'd225);

      // Mid-stream reset discards the in-flight result
      step(1'b0, 4'd3, 4'd4, 3'd0);
      check("add_3_4", 8'd7);
      step(1'b1, 4'd9, 4'd9, 3'd2);
      check("rst_midstream", 8'h00);
      step(1'b1, 4'hF, 4'h0, 3'd4);
      check("rst_held", 8'h00);
      step(1'b0, 4'hC, 4'hA, 3'd4);
      check("release_or", 8'h0E);

      // Full sweep against the golden model
      for (int c = 0; c < 8; c++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               step(1'b0, 4'(a), 4'(b), 3'(c));
               check("sweep", golden(4'(a), 4'(b), 3'(c)));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_gatelevel.md
ALU_GATELEVEL -- requirements
Module: alu_gatelevel

Interface
REQ-001 Parameter OP_W, default 4, operand width in bits.
REQ-002 Parameter RES_W, default 8 (2*OP_W), result width in bits.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_op1  input  4  operand A, unsigned.
REQ-006 i_op2  input  4  operand B, unsigned.
REQ-007 i_ctrl  input  3  operation select.
REQ-008 o_dat  output  8  registered result.

Function
REQ-009 The block SHALL compute a combinational result R from i_op1, i_op2 and i_ctrl, and register it into o_dat on each rising i_clk edge.
REQ-010 Latency SHALL be exactly 1 cycle: o_dat after edge N equals R for the inputs sampled at edge N.
REQ-011 There SHALL be no handshake and no stall; every cycle accepts a new operation.
REQ-012 i_ctrl=0 (ADD) SHALL give R = zero-extended i_op1 + i_op2, range 0..30.
REQ-013 i_ctrl=1 (SUB) SHALL give R = (i_op1 - i_op2) mod 256 in two's complement, e.g. 3-5 = 8'hFE.
REQ-014 i_ctrl=2 (MUL) SHALL give R = full unsigned 8-bit product i_op1*i_op2, range 0..225.
REQ-015 i_ctrl=3 (AND) SHALL give R = {4'b0, i_op1 & i_op2}.
REQ-016 i_ctrl=4 (OR) SHALL give R = {4'b0, i_op1 | i_op2}.
REQ-017 i_ctrl=5..7 (reserved) SHALL give R = 8'h00.
REQ-018 No arithmetic operation SHALL saturate or flag overflow; results wrap modulo 256 (only SUB can wrap).
REQ-019 R SHALL be a pure function of the current inputs, with no dependence on operation history.
REQ-020 The datapath SHALL be gate-level: adder, subtractor (A + ~B + 1), array multiplier, AND/OR and the result mux built only from and/or/xor/not primitives. Only the output register and its reset logic SHALL be behavioral.

Reset
REQ-021 When i_rst=1 at a rising i_clk edge, o_dat SHALL become 8'h00 regardless of the other inputs.
REQ-022 When i_rst is deasserted, the first rising edge with i_rst=0 SHALL load R for the inputs present at that edge.
REQ-023 Asserting i_rst mid-stream SHALL discard the in-flight result; no pending value SHALL appear after reset.
REQ-024 o_dat SHALL hold its value between clock edges; asynchronous changes on the inputs SHALL NOT affect o_dat.

Structure
REQ-025 A shared package alu_pkg SHALL hold the opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_AND=3, OP_OR=4, the widths OP_W and RES_W, and the reserved-op result value 0.
REQ-026 One sub-module, full_adder (a, b, cin -> s, cout, gate primitives), SHALL be instantiated for the 8-bit ripple adder/subtractor and the multiplier partial-product rows.
REQ-027 A separate behavioral golden model (case statement on i_ctrl) with an identical port list and identical timing SHALL exist for verification only.

Verification
REQ-028 ADD: i_op1=15, i_op2=15, i_ctrl=0 -> o_dat=8'd30 one cycle later.
REQ-029 SUB: i_op1=3, i_op2=5, i_ctrl=1 -> o_dat=8'hFE; i_op1=9, i_op2=4 -> 8'd5.
REQ-030 MUL: i_op1=15, i_op2=15, i_ctrl=2 -> o_dat=8'd225; i_op1=0, i_op2=7 -> 8'd0.
REQ-031 Logic and reserved ops: i_op1=4'hC, i_op2=4'hA, i_ctrl=3 -> 8'h08; i_ctrl=4 -> 8'h0E; i_ctrl=6 -> 8'h00.
REQ-032 Reset: drive i_ctrl=2 with 15*15, then assert i_rst for one edge -> o_dat=8'h00; deassert -> o_dat=225 on the next edge.
REQ-033 Exhaustive sweep: i_ctrl 0..7 x i_op1 0..15 x i_op2 0..15, one vector per cycle -> o_dat equals the golden model output every cycle, with an error count of 0.
